// File: rtl/demux_buffered.sv
// Buffered 1-to-2 demultiplexer: each accepted word is steered by `selector`
// into one of two independent valid/ready FIFOs.
`timescale 1ns/1ps

module demux_buffered #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     selector,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [WIDTH-1:0]         dout       [2],
    output logic [1:0]               dout_valid,
    input  logic [1:0]               dout_ready,
    output logic [$clog2(DEPTH):0]   level      [2]
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    logic [1:0] ch_full;

    // Head-of-line: the input stalls only when the addressed channel is full.
    assign din_ready = !ch_full[selector];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [LW-1:0]    count;
        logic             push;
        logic             pop;
        state_t           state;

        // NOTE: every variable written in always_comb gets a default first,
        // otherwise an unassigned path infers a latch.
        always_comb begin
            state = PARTIAL;
            if (count == '0)
                state = EMPTY;
            else if (count == LW'(DEPTH))
                state = FULL;
        end

        assign push = din_valid && din_ready && (selector == 1'(c));
        assign pop  = (state != EMPTY) && dout_ready[c];

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + LW'(1);
                    2'b01:   count <= count - LW'(1);
                    default: count <= count;
                endcase
            end
        end

        // NOTE: storage is not reset; validity comes solely from count.
        always_ff @(posedge clk) begin
            if (push)
                mem[wr_ptr] <= din;
        end

        assign ch_full[c]    = (state == FULL);
        assign dout[c]       = mem[rd_ptr];
        assign dout_valid[c] = (state != EMPTY);
        assign level[c]      = count;
    end

endmodule

// File: tb/tb_demux_buffered.sv
// Self-checking bench for demux_buffered: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps

module tb_demux_buffered;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             selector = 1'b0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic [WIDTH-1:0] dout [2];
    logic [1:0]       dout_valid;
    logic [1:0]       dout_ready = 2'b00;
    logic [LW-1:0]    level [2];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q [2][$];
    logic [WIDTH-1:0] popped1 [$];
    bit               chk_en = 1'b0;
    bit               log_en = 1'b0;
    int               max_lvl1 = 0;
    bit               acc = 1'b0;

    demux_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .selector   (selector),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: two bounded queues, updated from the inputs seen at each edge.
    always @(posedge clk) begin : model
        bit push;
        push = din_valid && (q[selector].size() < DEPTH);
        if (rst) begin
            q[0].delete();
            q[1].delete();
        end else begin
            for (int i = 0; i < 2; i++)
                if (dout_ready[i] && q[i].size() > 0)
                    void'(q[i].pop_front());
            if (push)
                q[selector].push_back(din);
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("din_ready", 64'(din_ready), 64'(q[selector].size() < DEPTH));
            for (int i = 0; i < 2; i++) begin
                check($sformatf("dout_valid[%0d]", i), 64'(dout_valid[i]), 64'(q[i].size() != 0));
                check($sformatf("level[%0d]", i), 64'(level[i]), 64'(q[i].size()));
                if (q[i].size() != 0)
                    check($sformatf("dout[%0d]", i), 64'(dout[i]), 64'(q[i][0]));
            end
            if (log_en) begin
                if (int'(level[1]) > max_lvl1)
                    max_lvl1 = int'(level[1]);
                if (dout_valid[1] && dout_ready[1])
                    popped1.push_back(dout[1]);
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset dout_valid", 64'(dout_valid), 64'(2'b00));
        check("reset level0", 64'(level[0]), 64'd0);
        check("reset level1", 64'(level[1]), 64'd0);
        check("reset din_ready sel0", 64'(din_ready), 64'd1);
        selector = 1'b1;
        #1;
        check("reset din_ready sel1", 64'(din_ready), 64'd1);

        // Select first / select second
        din = 32'h0000A5A5; selector = 1'b0; din_valid = 1'b1; dout_ready = 2'b11;
        tick();
        din = 32'h00005A5A; selector = 1'b1;
        #1;
        check("sel0 valid", 64'(dout_valid), 64'(2'b01));
        check("sel0 data", 64'(dout[0]), 64'h0000A5A5);
        tick();
        din_valid = 1'b0;
        #1;
        check("sel1 valid", 64'(dout_valid), 64'(2'b10));
        check("sel1 data", 64'(dout[1]), 64'h00005A5A);
        tick();
        #1;
        check("sel single cycle", 64'(dout_valid), 64'(2'b00));

        // Fill and back-pressure on channel 0
        dout_ready = 2'b10;
        din = 32'h1; selector = 1'b0; din_valid = 1'b1;
        tick();
        din = 32'h2;
        tick();
        din = 32'h3;
        #1;
        check("fill level0", 64'(level[0]), 64'd2);
        check("fill ready sel0", 64'(din_ready), 64'd0);
        din_valid = 1'b0; selector = 1'b1;
        #1;
        check("fill ready sel1", 64'(din_ready), 64'd1);
        selector = 1'b0; din_valid = 1'b1;
        tick();
        #1;
        check("stall level0", 64'(level[0]), 64'd2);
        check("stall head0", 64'(dout[0]), 64'h1);
        dout_ready = 2'b11;
        tick();
        dout_ready = 2'b10;
        #1;
        check("after pop level0", 64'(level[0]), 64'd1);
        check("after pop head0", 64'(dout[0]), 64'h2);
        check("after pop ready", 64'(din_ready), 64'd1);
        tick();
        din_valid = 1'b0;
        #1;
        check("3 accepted level0", 64'(level[0]), 64'd2);
        check("3 accepted head0", 64'(dout[0]), 64'h2);

        // Independent channels: channel 0 full and stalled
        dout_ready = 2'b00;
        din = 32'hCAFE; selector = 1'b1; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        #1;
        check("indep valid1", 64'(dout_valid[1]), 64'd1);
        check("indep data1", 64'(dout[1]), 64'hCAFE);
        check("indep level0", 64'(level[0]), 64'd2);
        check("indep head0", 64'(dout[0]), 64'h2);
        dout_ready = 2'b01;
        tick();
        #1;
        check("indep second0", 64'(dout[0]), 64'h3);
        check("indep level0 after pop", 64'(level[0]), 64'd1);
        dout_ready = 2'b11;
        repeat (3) tick();

        // Ordering with simultaneous push and pop on channel 1
        k = 0;
        max_lvl1 = 0;
        log_en = 1'b1;
        for (int cyc = 0; cyc < 40 && (k < 8 || popped1.size() < 8); cyc++) begin
            din_valid = (k < 8);
            din = 32'h10 + k;
            selector = 1'b1;
            dout_ready = {cyc[0], 1'b1};
            #1;
            acc = din_valid && din_ready;
            tick();
            if (acc)
                k++;
        end
        din_valid = 1'b0;
        log_en = 1'b0;
        check("stream count", 64'(popped1.size()), 64'd8);
        for (int j = 0; j < popped1.size(); j++)
            check($sformatf("stream word %0d", j), 64'(popped1[j]), 64'(32'h10 + j));
        check("stream max level1 within 2", 64'(max_lvl1 <= 2), 64'd1);

        // Reset mid-operation with both channels holding two words
        dout_ready = 2'b00;
        for (int j = 0; j < 4; j++) begin
            din = 32'h100 + j; selector = j[0]; din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        #1;
        check("prefill level0", 64'(level[0]), 64'd2);
        check("prefill level1", 64'(level[1]), 64'd2);
        din = 32'hDEAD; selector = 1'b0; din_valid = 1'b1; dout_ready = 2'b11;
        rst = 1'b1;
        tick();
        rst = 1'b0; din_valid = 1'b0;
        #1;
        check("midrst dout_valid", 64'(dout_valid), 64'(2'b00));
        check("midrst level0", 64'(level[0]), 64'd0);
        check("midrst level1", 64'(level[1]), 64'd0);
        check("midrst din_ready", 64'(din_ready), 64'd1);
        repeat (3) tick();
        check("midrst no stale words", 64'(dout_valid), 64'(2'b00));

        // Randomized traffic with occasional resets
        acc = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!din_valid || acc) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din = $urandom;
                selector = 1'($urandom_range(0, 1));
            end
            dout_ready = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) == 0);
            #1;
            acc = din_valid && din_ready && !rst;
            tick();
        end
        rst = 1'b0;
        din_valid = 1'b0;
        dout_ready = 2'b11;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
